serial_add_ctrl: RTL
====================

# serial_add_ctrl

Sequencer that time-shares one full-adder cell, built from two instances of the team's half-adder cell, to add two WIDTH-bit operands bit-serially, LSB first. It sits between the pin-level wrapper and the adder datapath. It owns operand latching, carry state, bit counting and the start/busy/done handshake, so the datapath stays a single 1-bit cell regardless of WIDTH.

## Interface
Parameters:
- WIDTH, default 8: operand and result width in bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  reset; synchronous, active-high
- start  input  1  request to begin an addition; sampled every cycle
- a  input  WIDTH  operand A; sampled only on an accepted start
- b  input  WIDTH  operand B; sampled only on an accepted start
- busy  output  1  high while bits are being processed
- done  output  1  single-cycle completion pulse
- sum  output  WIDTH  registered result, A+B mod 2^WIDTH
- cout  output  1  registered carry-out of bit WIDTH-1

## Operation
- Reset (rst=1 at a clock edge) forces the following, regardless of the current state, including mid-operation:
  - state IDLE; busy=0, done=0, sum=0, cout=0
  - internal shift registers, carry and counter all cleared
  - the partial result is discarded
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1: latch a→a_sr, b→b_sr, carry←0, cnt←0, then go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - Full-add a_sr[0], b_sr[0] and carry using two half-adder cells: s1,c1 = HA(a_sr[0], b_sr[0]); bit,c2 = HA(s1, carry); next carry = c1|c2.
  - Shift bit into res_sr at the MSB end, shifting right.
  - Shift a_sr and b_sr right by one; cnt←cnt+1.
  - When cnt==WIDTH-1: load sum←final res_sr (including this cycle's bit) and cout←next carry, then go to DONE.
- DONE, one cycle only, with done=1:
  - start=1: accepted exactly as in IDLE (back-to-back operation) and go to RUN.
  - Otherwise go to IDLE.
- start is ignored in RUN. Operands presented during RUN are not latched, and no error is flagged.
- sum and cout change only on entry to DONE or on reset. They hold their value through IDLE and through any subsequent RUN.
- busy = (state==RUN). done = (state==DONE). Both are decoded directly from the state register, with no combinational path from start.
- cnt width is clog2(WIDTH). The counter does not wrap within an operation, because the comparison against WIDTH-1 terminates the run.

## Timing
- Handshake: start is sampled at edge 0 (state IDLE or DONE).
- busy is high for cycles 1..WIDTH, exactly WIDTH cycles.
- done is high in cycle WIDTH+1; sum and cout are valid from cycle WIDTH+1 onward.
- Throughput:
  - Back-to-back: one result per WIDTH+1 cycles, with start held or re-asserted in the DONE cycle.
  - With an idle gap: one result per WIDTH+2 cycles minimum.
- rst takes priority over start when both are high at the same edge.
- Outputs are all registered, so no input-to-output combinational path exists.

## Structure
- Shared package serial_add_pkg:
  - state enum {IDLE, RUN, DONE}
  - DEFAULT_WIDTH=8
- One sub-module, ha_cell (inputs x, y; outputs s = x^y, c = x&y). It is instantiated twice to form the full-adder cell and is reused unchanged by the pin-level wrapper.
- The controller holds all state: FSM, counter, operand and result shift registers, and the carry flop.

## Test plan
- WIDTH=8, start with a=8'h5A, b=8'h3C → busy for 8 cycles, done pulse in cycle 9, sum=8'h96, cout=0.
- a=8'hFF, b=8'h01 → sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF → sum=8'hFE, cout=1.
- Pulse start again in cycle 3 of a run with different operands → ignored; the original result is produced and done is still in cycle 9.
- Assert rst in cycle 4 of a run → next cycle busy=0, done=0, sum=0, cout=0. A fresh start then yields the correct result.
- Back-to-back: start held high continuously with 8'h01+8'h02, then 8'h80+8'h80 → done in cycles 9 and 18, results 8'h03/0 then 8'h00/1. sum holds 8'h03 during the second run.
- Idle hold: after a completion, 20 idle cycles with start=0 → busy=0, done=0, and sum/cout are unchanged.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_add_pkg;

  // Sequencer states: waiting, shifting bits through the adder cell, result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage : serial_add_pkg

// File: rtl/serial_add_ctrl_ha_cell.sv
// Half-adder cell; two of these form the 1-bit full-adder datapath.
module ha_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  // Sum and carry of two single bits.
  always_comb begin
    s = x ^ y;
    c = x & y;
  end

endmodule : ha_cell

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: latches operands on start, feeds one bit per
// cycle (LSB first) through a shared full-adder cell and publishes the
// registered sum/carry-out when the last bit has been processed.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic [WIDTH-1:0] res_sr_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;

  logic             s1_s;
  logic             c1_s;
  logic             bit_s;
  logic             c2_s;
  logic             carry_next_s;
  logic [WIDTH-1:0] res_next_s;

  // Full adder built from two half-adder cells on the current LSBs and carry.
  ha_cell u_ha_ab (
    .x (a_sr_r[0]),
    .y (b_sr_r[0]),
    .s (s1_s),
    .c (c1_s)
  );

  ha_cell u_ha_carry (
    .x (s1_s),
    .y (carry_r),
    .s (bit_s),
    .c (c2_s)
  );

  // Next carry and the result register with this cycle's bit entering at the MSB.
  always_comb begin
    carry_next_s = c1_s | c2_s;
    res_next_s   = {bit_s, res_sr_r[WIDTH-1:1]};
  end

  // Sequencer FSM with operand/result shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      a_sr_r   <= '0;
      b_sr_r   <= '0;
      res_sr_r <= '0;
      carry_r  <= 1'b0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      sum_r    <= '0;
      cout_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done_r <= 1'b0;
          if (start) begin
            a_sr_r   <= a;
            b_sr_r   <= b;
            res_sr_r <= '0;
            carry_r  <= 1'b0;
            cnt_r    <= '0;
            busy_r   <= 1'b1;
            state_r  <= RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          res_sr_r <= res_next_s;
          a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
          carry_r  <= carry_next_s;
          cnt_r    <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            sum_r   <= res_next_s;
            cout_r  <= carry_next_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    busy = busy_r;
    done = done_r;
    sum  = sum_r;
    cout = cout_r;
  end

endmodule : serial_add_ctrl
